shift_seq_ctrl: RTL

//   Multi-cycle shift controller for the SimpleALU shift path. Accepts one operation
//   per valid/ready handshake and shifts the operand one bit per clock. Covers logical

---
 rtl/shift_seq_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift/rotate controller for the SimpleALU shift path.
// It accepts one op per handshake, shifts one bit per clock and holds the result until it is taken.
module shift_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned LOG_W = $clog2(WIDTH);

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpRol = 2'b10;
  localparam logic [1:0] OpRor = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] shreg_step;
  logic [CNT_W-1:0] steps_req;
  logic             accept;

  assign accept = in_valid_i && (state_q == StIdle);

  // Linear shifts saturate at WIDTH steps (result all zeros); rotates wrap modulo WIDTH.
  always_comb begin
    steps_req = '0;
    if (op_i == OpRol || op_i == OpRor) begin
      steps_req = CNT_W'(b_i[LOG_W-1:0]);
    end else if (b_i >= WIDTH'(WIDTH)) begin
      steps_req = CNT_W'(WIDTH);
    end else begin
      steps_req = CNT_W'(b_i);
    end
  end

  always_comb begin
    shreg_step = shreg_q;
    unique case (op_q)
      OpSll:   shreg_step = {shreg_q[WIDTH-2:0], 1'b0};
      OpSrl:   shreg_step = {1'b0, shreg_q[WIDTH-1:1]};
      OpRol:   shreg_step = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
      OpRor:   shreg_step = {shreg_q[0], shreg_q[WIDTH-1:1]};
      default: shreg_step = shreg_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      cnt_q       <= '0;
      op_q        <= OpSll;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush_i) begin
      // Abort drops the op but leaves the last result visible.
      state_q     <= StIdle;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            shreg_q <= a_i;
            op_q    <= op_i;
            cnt_q   <= steps_req;
            busy_q  <= 1'b1;
            if (steps_req == '0) begin
              state_q     <= StDone;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          shreg_q <= shreg_step;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign result_o    = shreg_q;

endmodule
